// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: carries the decoded control bundle from ID through EX, MEM and WB.
// It also makes the two pipeline-control decisions that use those signals:
//   - load-use stall: a load in EX whose rd matches an ID source register;
//   - branch-taken flush: a taken branch in EX squashes the ID instruction.
// Optional feature macro: CTRL_PIPE_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
// A stage with valid=0 always presents all-zero controls (a bubble).
module ctrl_pipe_regs #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic [1:0]        id_aluop,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              ex_valid,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic              mem_regwrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_rd
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // EX stage registers
    logic              r_ex_valid;
    logic              r_ex_branch;
    logic              r_ex_memread;
    logic              r_ex_memtoreg;
    logic              r_ex_memwrite;
    logic              r_ex_alusrc;
    logic              r_ex_regwrite;
    logic [1:0]        r_ex_aluop;
    logic [REG_AW-1:0] r_ex_rd;

    // MEM stage registers (branch/ALU fields are consumed in EX)
    logic              r_mem_valid;
    logic              r_mem_memread;
    logic              r_mem_memwrite;
    logic              r_mem_memtoreg;
    logic              r_mem_regwrite;
    logic [REG_AW-1:0] r_mem_rd;

    // WB stage registers
    logic              r_wb_valid;
    logic              r_wb_memtoreg;
    logic              r_wb_regwrite;
    logic [REG_AW-1:0] r_wb_rd;

    logic w_take;
    logic w_hazard;
    logic w_bubble;

    // Hazard/flush decisions: current ID fields against the EX registers only,
    // so no registered output ever feeds back on itself combinationally.
    always_comb begin
        w_take   = r_ex_valid & r_ex_branch & ex_branch_taken;
        w_hazard = id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != '0)
                 & ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
        // Flush wins over stall; either one, or an empty ID slot, injects a bubble.
        w_bubble = ~id_valid | w_take | w_hazard;
    end

    assign flush = w_take;
    assign stall = w_hazard & ~w_take;

    // EX register: take the ID bundle unless a bubble is being inserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_branch   <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_aluop    <= 2'b00;
            r_ex_rd       <= '0;
        end else if (w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_branch   <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_aluop    <= 2'b00;
            r_ex_rd       <= '0;
        end else begin
            r_ex_valid    <= 1'b1;
            r_ex_branch   <= id_branch;
            r_ex_memread  <= id_memread;
            r_ex_memtoreg <= id_memtoreg;
            r_ex_memwrite <= id_memwrite;
            r_ex_alusrc   <= id_alusrc;
            r_ex_regwrite <= id_regwrite;
            r_ex_aluop    <= id_aluop;
            r_ex_rd       <= id_rd;
        end
    end

    // MEM register: always advances from EX (a taken branch itself moves on).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= '0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_rd       <= r_ex_rd;
        end
    end

    // WB register: always advances from MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid    <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
        end else begin
            r_wb_valid    <= r_mem_valid;
            r_wb_memtoreg <= r_mem_memtoreg;
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_rd       <= r_mem_rd;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_branch    = r_ex_branch;
    assign ex_memread   = r_ex_memread;
    assign ex_memtoreg  = r_ex_memtoreg;
    assign ex_memwrite  = r_ex_memwrite;
    assign ex_alusrc    = r_ex_alusrc;
    assign ex_regwrite  = r_ex_regwrite;
    assign ex_aluop     = r_ex_aluop;
    assign ex_rd        = r_ex_rd;
    assign mem_valid    = r_mem_valid;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_memtoreg = r_mem_memtoreg;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_rd       = r_mem_rd;
    assign wb_valid     = r_wb_valid;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_rd        = r_wb_rd;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Event counters: count stall/flush cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
